npu_in_loader: RTL and testbench
================================

NPU_IN_LOADER -- requirements
Module: npu_in_loader

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16'd1000: number of WAIT_DONE cycles after which a missing DONE is declared a timeout.
REQ-002 The block SHALL have parameter FRAME_BYTES, default 5, fixed: bytes per frame, in the order DA, DB, DC, DD, BIAS.
Ports (name, direction, width, meaning):
REQ-003 CLKEXT  in  1  the single clock; all logic is rising-edge.
REQ-004 RST_GLO_N  in  1  reset, asynchronous, active-low.
REQ-005 S_VALID  in  1  host byte valid.
REQ-006 S_DATA  in  8  host byte.
REQ-007 S_READY  out  1  loader accepts a byte this cycle.
REQ-008 NPU_DONE  in  1  DONE from the NPU core.
REQ-009 CLR_ERR  in  1  single-cycle pulse that clears the timeout state.
REQ-010 DA, DB, DC, DD  out  8 each  registered operand lanes to the NPU core.
REQ-011 BIAS_IN  out  8  registered bias to the NPU core.
REQ-012 START  out  1  single-cycle start pulse to the NPU core.
REQ-013 LOADER_BUSY  out  1  high in every state except COLLECT.
REQ-014 TIMEOUT  out  1  sticky error flag.
REQ-015 FRAME_CNT  out  16  count of completed frames.

Function
REQ-016 The FSM SHALL have four states: COLLECT, ISSUE, WAIT_DONE and ERROR; COLLECT is the reset state.
REQ-017 S_READY SHALL be 1 only in COLLECT; a byte is accepted only on a cycle with S_VALID=1 and S_READY=1.
REQ-018 A 3-bit byte index (0..4) SHALL route each accepted byte: 0->DA, 1->DB, 2->DC, 3->DD, 4->BIAS_IN; the output register updates on the edge the byte is accepted.
REQ-019 Acceptance of byte 4 SHALL reset the index to 0 and take the FSM to ISSUE on the next edge.
REQ-020 While S_VALID=0, COLLECT SHALL hold both the index and the operand registers unchanged; there is no inter-byte timeout.
REQ-021 In ISSUE, START SHALL be 1 for exactly one cycle, and the FSM SHALL then move unconditionally to WAIT_DONE.
REQ-022 DA..DD and BIAS_IN SHALL be held stable from ISSUE until leaving WAIT_DONE, covering the core's start synchronizer and its load cycle.
REQ-023 In WAIT_DONE, a 16-bit wait counter SHALL increment every cycle starting from 0.
REQ-024 NPU_DONE=1 in WAIT_DONE SHALL take the FSM to COLLECT and increment FRAME_CNT by 1.
REQ-025 FRAME_CNT SHALL wrap from 16'hFFFF to 16'h0000.
REQ-026 When the wait counter equals TIMEOUT_CYC-1 and NPU_DONE=0, the FSM SHALL go to ERROR and set TIMEOUT=1; FRAME_CNT is not incremented.
REQ-027 If NPU_DONE=1 on the same cycle the timeout would fire, DONE SHALL win: go to COLLECT, increment FRAME_CNT, leave TIMEOUT=0.
REQ-028 NPU_DONE SHALL be ignored in COLLECT, ISSUE and ERROR.
REQ-029 In ERROR, S_READY=0 and START=0; CLR_ERR=1 SHALL clear TIMEOUT, clear the index and go to COLLECT.
REQ-030 CLR_ERR SHALL be ignored in all states other than ERROR.
REQ-031 START, S_READY, LOADER_BUSY and TIMEOUT SHALL be driven directly from state or registers, with no combinational path from S_VALID or NPU_DONE.

Reset
REQ-032 Asserting RST_GLO_N=0 SHALL immediately force: state=COLLECT, index=0, wait counter=0, DA=DB=DC=DD=BIAS_IN=8'h00, START=0, TIMEOUT=0, FRAME_CNT=0.
REQ-033 S_READY SHALL read 1 and LOADER_BUSY 0 after the first edge out of reset.
REQ-034 A reset mid-frame or mid-wait SHALL discard the partial frame with no START pulse.
REQ-035 Reset deassertion SHALL be synchronized externally and is not handled in this block.

Structure
REQ-036 State encodings (COLLECT=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2, ERROR=2'd3), FRAME_BYTES and the default TIMEOUT_CYC SHALL live in the shared NPU constants include file.
REQ-037 The block SHALL be one flat module; the only natural sub-module is npu_wait_timer (the wait counter with its compare), which is optional.

Verification
REQ-038 Bytes 11,22,33,44,05 sent back-to-back, DONE asserted 8 cycles after START -> DA..BIAS_IN=11/22/33/44/05, exactly one START, FRAME_CNT=1, S_READY=1 one cycle after DONE.
REQ-039 Same frame with S_VALID toggling 1,0,1,0 -> identical register values; START occurs once, after the fifth accepted byte.
REQ-040 TIMEOUT_CYC=20 and no DONE -> TIMEOUT=1 exactly 20 cycles after entering WAIT_DONE, S_READY=0; CLR_ERR pulse -> COLLECT with TIMEOUT=0, FRAME_CNT unchanged.
REQ-041 DONE asserted on the cycle the timeout would fire -> no TIMEOUT, FRAME_CNT incremented.
REQ-042 Reset pulse after 3 bytes accepted -> all outputs 0, no START; a subsequent full frame loads correctly.
REQ-043 FRAME_CNT preset to 16'hFFFF by running 65535 frames (or by a forced preload) then one more frame -> FRAME_CNT=16'h0000.

Source files
------------

// File: rtl/npu_in_loader_pkg.sv
// Shared NPU loader constants: FSM state encoding, frame geometry and the
// default DONE timeout.
package npu_in_loader_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ERROR     = 2'd3
  } state_t;

  localparam int          NPU_FRAME_BYTES = 5;
  localparam logic [15:0] NPU_TIMEOUT_CYC = 16'd1000;

  // Index value of the last byte in a frame (the BIAS byte).
  function automatic logic [2:0] lastIndex(input int frameBytes);
    return 3'(frameBytes - 1);
  endfunction

endpackage

// File: rtl/npu_in_loader_if.sv
// Host byte stream, NPU core handshake and status bundle of the input loader.
// The slave modport is the loader's view; master is the host/core side.
interface npu_in_loader_if;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        npu_done;
  logic        clr_err;
  logic [7:0]  da;
  logic [7:0]  db;
  logic [7:0]  dc;
  logic [7:0]  dd;
  logic [7:0]  bias_in;
  logic        start;
  logic        loader_busy;
  logic        timeout;
  logic [15:0] frame_cnt;

  modport slave (
    input  s_valid, s_data, npu_done, clr_err,
    output s_ready, da, db, dc, dd, bias_in, start, loader_busy, timeout, frame_cnt
  );

  modport master (
    output s_valid, s_data, npu_done, clr_err,
    input  s_ready, da, db, dc, dd, bias_in, start, loader_busy, timeout, frame_cnt
  );

endinterface

// File: rtl/npu_in_loader_wait_timer.sv
// Wait counter for the DONE handshake: counts up from zero while the loader
// sits in WAIT_DONE and flags the cycle on which the timeout would fire.
module npu_wait_timer #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_expire
);

  logic [15:0] r_cnt;

  // Count while running, otherwise park at zero so every wait starts fresh.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= 16'd0;
    end
  end

  assign o_expire = i_run && (r_cnt == (TIMEOUT_CYC - 16'd1));

endmodule

// File: rtl/npu_in_loader.sv
// NPU input loader: collects a five-byte frame (DA, DB, DC, DD, BIAS) from the
// host, pulses START to the core, then waits for DONE with a timeout guard.
module npu_in_loader
  import npu_in_loader_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = NPU_TIMEOUT_CYC,
  parameter int          FRAME_BYTES = NPU_FRAME_BYTES
) (
  input  logic            i_clkext,
  input  logic            i_rst_glo_n,
  npu_in_loader_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = lastIndex(FRAME_BYTES);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_da;
  logic [7:0]  r_db;
  logic [7:0]  r_dc;
  logic [7:0]  r_dd;
  logic [7:0]  r_bias;
  logic        r_start;
  logic        r_ready;
  logic        r_busy;
  logic        r_timeout;
  logic [15:0] r_frame_cnt;

  logic        w_accept;
  logic        w_run;
  logic        w_expire;

  assign w_accept = bus.s_valid && r_ready;
  assign w_run    = (r_state == ST_WAIT_DONE);

  npu_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .i_clk    (i_clkext),
    .i_rst_n  (i_rst_glo_n),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  // Loader FSM; ready/busy/start are registered alongside the state change so
  // no host or core input reaches them combinationally. Operand registers only
  // move on accepted bytes, which keeps them stable through ISSUE and WAIT_DONE.
  always_ff @(posedge i_clkext or negedge i_rst_glo_n) begin
    if (!i_rst_glo_n) begin
      r_state     <= ST_COLLECT;
      r_idx       <= 3'd0;
      r_da        <= 8'h00;
      r_db        <= 8'h00;
      r_dc        <= 8'h00;
      r_dd        <= 8'h00;
      r_bias      <= 8'h00;
      r_start     <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_timeout   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (w_accept) begin
            case (r_idx)
              3'd0:    r_da   <= bus.s_data;
              3'd1:    r_db   <= bus.s_data;
              3'd2:    r_dc   <= bus.s_data;
              3'd3:    r_dd   <= bus.s_data;
              3'd4:    r_bias <= bus.s_data;
              default: r_idx  <= 3'd0;
            endcase
            if (r_idx == LAST_IDX) begin
              r_idx   <= 3'd0;
              r_state <= ST_ISSUE;
              r_start <= 1'b1;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_DONE;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
        ST_WAIT_DONE: begin
          if (bus.npu_done) begin
            r_state     <= ST_COLLECT;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
          end else if (w_expire) begin
            r_state   <= ST_ERROR;
            r_timeout <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (bus.clr_err) begin
            r_state   <= ST_COLLECT;
            r_timeout <= 1'b0;
            r_idx     <= 3'd0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign bus.s_ready     = r_ready;
  assign bus.da          = r_da;
  assign bus.db          = r_db;
  assign bus.dc          = r_dc;
  assign bus.dd          = r_dd;
  assign bus.bias_in     = r_bias;
  assign bus.start       = r_start;
  assign bus.loader_busy = r_busy;
  assign bus.timeout     = r_timeout;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_npu_in_loader.sv
// Directed testbench for the NPU input loader (TIMEOUT_CYC overridden to 20).
module tb_npu_in_loader;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;
  int   startCount = 0;
  int   startBase;

  npu_in_loader_if bus();

  npu_in_loader #(
    .TIMEOUT_CYC (16'd20)
  ) dut (
    .i_clkext    (clk),
    .i_rst_glo_n (rstN),
    .bus         (bus)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Tally every START pulse the core would see.
  always @(posedge clk) begin
    if (bus.start === 1'b1) startCount++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout byte %h never accepted, s_ready=%b want 1", b, bus.s_ready);
    end
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, b4);
    sendByte(b0); sendByte(b1); sendByte(b2); sendByte(b3); sendByte(b4);
  endtask

  // From the ISSUE cycle: wait n cycles, then hold DONE for one edge.
  task automatic finishFrame(input int n);
    for (int i = 0; i < n; i++) step();
    bus.npu_done = 1'b1;
    step();
    bus.npu_done = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.npu_done = 1'b0; bus.clr_err = 1'b0;
    #1;
    checks++;
    if ({bus.da, bus.db, bus.dc, bus.dd, bus.bias_in} !== 40'h0) begin
      errors++; $display("[TB] FAIL reset_operands got %h want 0", {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in});
    end
    checks++;
    if ({bus.start, bus.timeout, bus.frame_cnt} !== 18'h0) begin
      errors++; $display("[TB] FAIL reset_status got %h want 0", {bus.start, bus.timeout, bus.frame_cnt});
    end
    step(); step();
    rstN = 1'b1;
    step();
    checks++;
    if (bus.s_ready !== 1'b1 || bus.loader_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready got ready=%b busy=%b want 1/0", bus.s_ready, bus.loader_busy);
    end
  endtask

  task automatic test_back_to_back();
    startBase = startCount;
    sendFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'h05);
    checks++;
    if (bus.start !== 1'b1 || bus.s_ready !== 1'b0 || bus.loader_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_issue got start=%b ready=%b busy=%b want 1/0/1", bus.start, bus.s_ready, bus.loader_busy);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.start !== 1'b0 || bus.s_ready !== 1'b0 || bus.da !== 8'h11 || bus.bias_in !== 8'h05) begin
      errors++; $display("[TB] FAIL b2b_wait got start=%b ready=%b da=%h bias=%h want 0/0/11/05", bus.start, bus.s_ready, bus.da, bus.bias_in);
    end
    finishFrame(4);
    checks++;
    if ({bus.da, bus.db, bus.dc, bus.dd, bus.bias_in} !== 40'h1122334405) begin
      errors++; $display("[TB] FAIL b2b_operands got %h want 1122334405", {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in});
    end
    checks++;
    if (bus.frame_cnt !== 16'd1 || bus.s_ready !== 1'b1 || bus.timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_done got cnt=%0d ready=%b to=%b want 1/1/0", bus.frame_cnt, bus.s_ready, bus.timeout);
    end
    checks++;
    if (startCount - startBase !== 1) begin
      errors++; $display("[TB] FAIL b2b_start_count got %0d want 1", startCount - startBase);
    end
  endtask

  task automatic test_valid_toggle();
    startBase = startCount;
    sendByte(8'h11); step();
    sendByte(8'h22); step();
    sendByte(8'h33);
    bus.npu_done = 1'b1;
    step(); step(); step();
    bus.npu_done = 1'b0;
    checks++;
    if (bus.frame_cnt !== 16'd1 || bus.loader_busy !== 1'b0 || bus.db !== 8'h22 || startCount != startBase) begin
      errors++; $display("[TB] FAIL toggle_hold got cnt=%0d busy=%b db=%h starts=%0d want 1/0/22/0", bus.frame_cnt, bus.loader_busy, bus.db, startCount - startBase);
    end
    sendByte(8'h44); step();
    checks++;
    if (bus.start !== 1'b0 || bus.s_ready !== 1'b1 || startCount != startBase) begin
      errors++; $display("[TB] FAIL toggle_no_early_start got start=%b ready=%b starts=%0d want 0/1/0", bus.start, bus.s_ready, startCount - startBase);
    end
    sendByte(8'h05);
    checks++;
    if (bus.start !== 1'b1) begin
      errors++; $display("[TB] FAIL toggle_start got %b want 1", bus.start);
    end
    finishFrame(1);
    checks++;
    if ({bus.da, bus.db, bus.dc, bus.dd, bus.bias_in} !== 40'h1122334405 || bus.frame_cnt !== 16'd2 || startCount - startBase !== 1) begin
      errors++; $display("[TB] FAIL toggle_result got ops=%h cnt=%0d starts=%0d want 1122334405/2/1", {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in}, bus.frame_cnt, startCount - startBase);
    end
  endtask

  task automatic test_timeout();
    sendFrame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    step();
    for (int i = 0; i < 19; i++) step();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_early got %b want 0 at 19 cycles", bus.timeout);
    end
    step();
    checks++;
    if (bus.timeout !== 1'b1 || bus.s_ready !== 1'b0 || bus.loader_busy !== 1'b1 || bus.frame_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL timeout_fire got to=%b ready=%b busy=%b cnt=%0d want 1/0/1/2", bus.timeout, bus.s_ready, bus.loader_busy, bus.frame_cnt);
    end
    bus.npu_done = 1'b1;
    step();
    bus.npu_done = 1'b0;
    step();
    checks++;
    if (bus.timeout !== 1'b1 || bus.frame_cnt !== 16'd2 || bus.start !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_done_ignored got to=%b cnt=%0d start=%b ready=%b want 1/2/0/0", bus.timeout, bus.frame_cnt, bus.start, bus.s_ready);
    end
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    checks++;
    if (bus.timeout !== 1'b0 || bus.s_ready !== 1'b1 || bus.loader_busy !== 1'b0 || bus.frame_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL timeout_clear got to=%b ready=%b busy=%b cnt=%0d want 0/1/0/2", bus.timeout, bus.s_ready, bus.loader_busy, bus.frame_cnt);
    end
  endtask

  task automatic test_done_at_timeout();
    sendFrame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50);
    step();
    for (int i = 0; i < 19; i++) step();
    bus.npu_done = 1'b1;
    step();
    bus.npu_done = 1'b0;
    checks++;
    if (bus.timeout !== 1'b0 || bus.frame_cnt !== 16'd3 || bus.s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL done_wins got to=%b cnt=%0d ready=%b want 0/3/1", bus.timeout, bus.frame_cnt, bus.s_ready);
    end
  endtask

  task automatic test_clr_ignored();
    startBase = startCount;
    sendByte(8'hA1); sendByte(8'hA2);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    sendByte(8'hA3); sendByte(8'hA4); sendByte(8'hA5);
    checks++;
    if (bus.start !== 1'b1 || {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in} !== 40'hA1A2A3A4A5) begin
      errors++; $display("[TB] FAIL clr_in_collect got start=%b ops=%h want 1/a1a2a3a4a5", bus.start, {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in});
    end
    finishFrame(2);
    checks++;
    if (bus.frame_cnt !== 16'd4 || startCount - startBase !== 1) begin
      errors++; $display("[TB] FAIL clr_frame got cnt=%0d starts=%0d want 4/1", bus.frame_cnt, startCount - startBase);
    end
  endtask

  task automatic test_reset_midframe();
    sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
    startBase = startCount;
    rstN = 1'b0;
    #1;
    checks++;
    if ({bus.da, bus.db, bus.dc, bus.dd, bus.bias_in} !== 40'h0 || bus.frame_cnt !== 16'd0 || bus.start !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_clear got ops=%h cnt=%0d start=%b want 0/0/0", {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in}, bus.frame_cnt, bus.start);
    end
    step(); step();
    rstN = 1'b1;
    step(); step();
    checks++;
    if (startCount != startBase || bus.s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_no_start got starts=%0d ready=%b want 0/1", startCount - startBase, bus.s_ready);
    end
    sendFrame(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E);
    finishFrame(3);
    checks++;
    if ({bus.da, bus.db, bus.dc, bus.dd, bus.bias_in} !== 40'h5A6B7C8D9E || bus.frame_cnt !== 16'd1 || startCount - startBase !== 1) begin
      errors++; $display("[TB] FAIL midreset_reload got ops=%h cnt=%0d starts=%0d want 5a6b7c8d9e/1/1", {bus.da, bus.db, bus.dc, bus.dd, bus.bias_in}, bus.frame_cnt, startCount - startBase);
    end
  endtask

  task automatic test_frame_wrap();
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    #1;
    checks++;
    if (bus.frame_cnt !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL wrap_preload got %h want ffff", bus.frame_cnt);
    end
    step();
    sendFrame(8'h01, 8'h23, 8'h45, 8'h67, 8'h89);
    finishFrame(2);
    checks++;
    if (bus.frame_cnt !== 16'h0000 || bus.s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_count got %h ready=%b want 0000/1", bus.frame_cnt, bus.s_ready);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_back_to_back();
    test_valid_toggle();
    test_timeout();
    test_done_at_timeout();
    test_clr_ignored();
    test_reset_midframe();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
